fsram_access_ctrl: RTL and testbench

//  Sequencer/arbiter in front of the feature SRAM bank (SRAM_NUM dual-port 2048x16 macros).
//  - Port A (CLKA = clk) is write-only and is shared between two requesters:

---
 rtl/fsram_pkg.sv | 26 ++
 rtl/fsram_rr_arb2.sv | 48 ++++
 rtl/fsram_access_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_fsram_access_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsram_pkg.sv
// ---------------------------------------------------------------------------
// fsram_pkg
// Shared constants and types for the feature-SRAM access controller.
//   ADDR_W   : word address width per macro
//   DATA_W   : data width per macro
//   DEPTH    : words per macro (length of the zero-fill sweep)
//   CNT_W    : clear counter width (one bit wider than the address)
//   CNT_LAST : last address written by the zero-fill sweep
//   state_t  : init FSM states (ST_IDLE, ST_CLEAR, ST_DONE)
// ---------------------------------------------------------------------------
package fsram_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 2048;
  localparam int CNT_W  = ADDR_W + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage : fsram_pkg

// File: rtl/fsram_rr_arb2.sv
// ---------------------------------------------------------------------------
// fsram_rr_arb2
// Two-requester round-robin arbiter for the shared write port.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : arbitration enabled (no grants while low)
//   req_ld     : loader request
//   req_wb     : write-back request
//   gnt_ld     : loader granted this cycle (combinational)
//   gnt_wb     : write-back granted this cycle (combinational)
// At most one grant per cycle. When both request, the requester that was not
// granted last wins. The priority pointer moves only when a grant is issued,
// and comes out of reset favouring the loader.
// ---------------------------------------------------------------------------
module fsram_rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_ld,
  input  logic req_wb,
  output logic gnt_ld,
  output logic gnt_wb
);

  // 1: loader wins a tie, 0: write-back wins a tie
  logic prio_ld_reg;
  logic prio_ld_next;

  assign gnt_ld = en & req_ld & (~req_wb | prio_ld_reg);
  assign gnt_wb = en & req_wb & (~req_ld | ~prio_ld_reg);

  always_comb begin
    prio_ld_next = prio_ld_reg;
    if (gnt_ld) begin
      prio_ld_next = 1'b0;
    end else if (gnt_wb) begin
      prio_ld_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_ld_reg <= 1'b1;
    end else begin
      prio_ld_reg <= prio_ld_next;
    end
  end

endmodule : fsram_rr_arb2

// File: rtl/fsram_access_ctrl.sv
// ---------------------------------------------------------------------------
// fsram_access_ctrl
// Sequencer/arbiter in front of SRAM_NUM dual-port 2048x16 feature SRAM macros.
//   clk, rst_n             : clock (port B macros run on ~clk), async active-low reset
//   init_start/busy/done   : zero-fill sweep control and status
//   ld_* / wb_*            : two write requesters sharing port A (valid/ready,
//                            common address, per-lane mask, per-lane data)
//   rd_valid/ready/addr    : read request on port B
//   rd_data_valid/rd_data  : read return, one cycle after acceptance
//   CENA/WENA/AA/DA        : registered port A (write-only) macro controls
//   CENB/WENB/AB/DB/QB     : port B (read-only) macro controls and read data
// Lane i of every packed data bus lives at [(i+1)*DATA_W-1 -: DATA_W].
// ---------------------------------------------------------------------------
module fsram_access_ctrl
  import fsram_pkg::*;
#(
  parameter int SRAM_NUM = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         init_start,
  output logic                         init_busy,
  output logic                         init_done,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [ADDR_W-1:0]            ld_addr,
  input  logic [SRAM_NUM-1:0]          ld_mask,
  input  logic [SRAM_NUM*DATA_W-1:0]   ld_data,
  input  logic                         wb_valid,
  output logic                         wb_ready,
  input  logic [ADDR_W-1:0]            wb_addr,
  input  logic [SRAM_NUM-1:0]          wb_mask,
  input  logic [SRAM_NUM*DATA_W-1:0]   wb_data,
  input  logic                         rd_valid,
  output logic                         rd_ready,
  input  logic [ADDR_W-1:0]            rd_addr,
  output logic                         rd_data_valid,
  output logic [SRAM_NUM*DATA_W-1:0]   rd_data,
  output logic                         CENA,
  output logic [SRAM_NUM-1:0]          WENA,
  output logic [SRAM_NUM*ADDR_W-1:0]   AA,
  output logic [SRAM_NUM*DATA_W-1:0]   DA,
  output logic                         CENB,
  output logic [SRAM_NUM-1:0]          WENB,
  output logic [SRAM_NUM*ADDR_W-1:0]   AB,
  output logic [SRAM_NUM*DATA_W-1:0]   DB,
  input  logic [SRAM_NUM*DATA_W-1:0]   QB
);

  // -------------------------------------------------------------------------
  // Init FSM and clear counter
  // -------------------------------------------------------------------------
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             in_idle;
  logic             in_clear;

  assign in_idle  = (state_reg == ST_IDLE);
  assign in_clear = (state_reg == ST_CLEAR);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (init_start) begin
          state_next = ST_CLEAR;
          cnt_next   = '0;
        end
      end
      ST_CLEAR: begin
        // Counter parks on the last address instead of wrapping.
        if (cnt_reg == CNT_LAST) begin
          state_next = ST_DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // Port A arbitration (only while idle)
  // -------------------------------------------------------------------------
  logic gnt_ld;
  logic gnt_wb;

  fsram_rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (in_idle),
    .req_ld (ld_valid),
    .req_wb (wb_valid),
    .gnt_ld (gnt_ld),
    .gnt_wb (gnt_wb)
  );

  assign ld_ready = gnt_ld;
  assign wb_ready = gnt_wb;
  assign rd_ready = in_idle;

  // -------------------------------------------------------------------------
  // Port A write mux: clear sweep has precedence, then the granted requester
  // -------------------------------------------------------------------------
  logic [ADDR_W-1:0]          wr_addr;
  logic [SRAM_NUM-1:0]        wr_mask;
  logic [SRAM_NUM*DATA_W-1:0] wr_data;
  logic                       wr_fire;

  always_comb begin
    wr_addr = ld_addr;
    wr_mask = ld_mask;
    wr_data = ld_data;
    wr_fire = 1'b0;
    if (in_clear) begin
      wr_addr = cnt_reg[ADDR_W-1:0];
      wr_mask = '1;
      wr_data = '0;
      wr_fire = 1'b1;
    end else if (gnt_wb) begin
      wr_addr = wb_addr;
      wr_mask = wb_mask;
      wr_data = wb_data;
      wr_fire = 1'b1;
    end else if (gnt_ld) begin
      wr_fire = 1'b1;
    end
  end

  // Addresses are common to all lanes; replicate per macro.
  logic [SRAM_NUM*ADDR_W-1:0] aa_rep;
  logic [SRAM_NUM*ADDR_W-1:0] ab_rep;

  generate
    for (genvar gi = 0; gi < SRAM_NUM; gi++) begin : g_addr_rep
      assign aa_rep[gi*ADDR_W +: ADDR_W] = wr_addr;
      assign ab_rep[gi*ADDR_W +: ADDR_W] = rd_addr;
    end
  endgenerate

  logic                       cena_reg, cena_next;
  logic [SRAM_NUM-1:0]        wena_reg, wena_next;
  logic [SRAM_NUM*ADDR_W-1:0] aa_reg, aa_next;
  logic [SRAM_NUM*DATA_W-1:0] da_reg, da_next;

  always_comb begin
    cena_next = 1'b1;
    wena_next = '1;
    aa_next   = aa_reg;
    da_next   = da_reg;
    if (wr_fire) begin
      // A zero mask still takes the slot: enable low, no lane written.
      cena_next = 1'b0;
      wena_next = ~wr_mask;
      aa_next   = aa_rep;
      da_next   = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cena_reg <= 1'b1;
      wena_reg <= '1;
      aa_reg   <= '0;
      da_reg   <= '0;
    end else begin
      cena_reg <= cena_next;
      wena_reg <= wena_next;
      aa_reg   <= aa_next;
      da_reg   <= da_next;
    end
  end

  // -------------------------------------------------------------------------
  // Port B read and return pipe
  // Accept at edge t drives CENB/AB; the macro samples on the falling edge
  // inside the following cycle, so QB is stable for capture at edge t+1.
  // -------------------------------------------------------------------------
  logic                       rd_accept;
  logic                       cenb_reg;
  logic [SRAM_NUM*ADDR_W-1:0] ab_reg;
  logic                       rd_pend_reg;
  logic                       rd_data_valid_reg;
  logic [SRAM_NUM*DATA_W-1:0] rd_data_reg;

  assign rd_accept = rd_valid & rd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cenb_reg          <= 1'b1;
      ab_reg            <= '0;
      rd_pend_reg       <= 1'b0;
      rd_data_valid_reg <= 1'b0;
      rd_data_reg       <= '0;
    end else begin
      cenb_reg          <= ~rd_accept;
      rd_pend_reg       <= rd_accept;
      rd_data_valid_reg <= rd_pend_reg;
      if (rd_accept) begin
        ab_reg <= ab_rep;
      end
      if (rd_pend_reg) begin
        rd_data_reg <= QB;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Init status flags, aligned with the registered port A activity
  // -------------------------------------------------------------------------
  logic init_busy_reg;
  logic init_done_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_busy_reg <= 1'b0;
      init_done_reg <= 1'b0;
    end else begin
      init_busy_reg <= in_clear;
      init_done_reg <= (state_reg == ST_DONE);
    end
  end

  assign init_busy     = init_busy_reg;
  assign init_done     = init_done_reg;
  assign rd_data_valid = rd_data_valid_reg;
  assign rd_data       = rd_data_reg;
  assign CENA          = cena_reg;
  assign WENA          = wena_reg;
  assign AA            = aa_reg;
  assign DA            = da_reg;
  assign CENB          = cenb_reg;
  assign WENB          = '1;
  assign AB            = ab_reg;
  assign DB            = '0;

endmodule : fsram_access_ctrl

// File: tb/tb_fsram_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fsram_access_ctrl
// Directed bench for fsram_access_ctrl with a behavioural dual-port SRAM bank:
// port A writes on clk rise, port B reads on clk fall.
// ---------------------------------------------------------------------------
module tb_fsram_access_ctrl;
  import fsram_pkg::*;

  localparam int N  = 8;
  localparam int DW = N * DATA_W;
  localparam int AW = N * ADDR_W;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            init_start = 1'b0;
  logic            init_busy, init_done;
  logic            ld_valid = 1'b0, wb_valid = 1'b0, rd_valid = 1'b0;
  logic            ld_ready, wb_ready, rd_ready;
  logic [ADDR_W-1:0] ld_addr = '0, wb_addr = '0, rd_addr = '0;
  logic [N-1:0]    ld_mask = '0, wb_mask = '0;
  logic [DW-1:0]   ld_data = '0, wb_data = '0;
  logic            rd_data_valid;
  logic [DW-1:0]   rd_data;
  logic            CENA, CENB;
  logic [N-1:0]    WENA, WENB;
  logic [AW-1:0]   AA, AB;
  logic [DW-1:0]   DA, DB;
  logic [DW-1:0]   QB = '0;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  fsram_access_ctrl #(.SRAM_NUM(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .init_start(init_start), .init_busy(init_busy), .init_done(init_done),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_mask(ld_mask), .ld_data(ld_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_mask(wb_mask), .wb_data(wb_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rd_data_valid(rd_data_valid), .rd_data(rd_data),
    .CENA(CENA), .WENA(WENA), .AA(AA), .DA(DA),
    .CENB(CENB), .WENB(WENB), .AB(AB), .DB(DB), .QB(QB)
  );

  // Behavioural SRAM bank
  logic [DATA_W-1:0] mem [N][DEPTH];

  always @(posedge clk) begin
    if (!CENA) begin
      for (int l = 0; l < N; l++) begin
        if (!WENA[l]) mem[l][AA[l*ADDR_W +: ADDR_W]] <= DA[l*DATA_W +: DATA_W];
      end
    end
  end

  always @(negedge clk) begin
    if (!CENB) begin
      for (int l = 0; l < N; l++) begin
        QB[l*DATA_W +: DATA_W] <= mem[l][AB[l*ADDR_W +: ADDR_W]];
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Issues one read and returns the captured data after the return cycle.
  task automatic do_read(input logic [ADDR_W-1:0] a, output logic [DW-1:0] d, output logic v);
    rd_valid = 1'b1;
    rd_addr  = a;
    tick();
    rd_valid = 1'b0;
    tick();
    d = rd_data;
    v = rd_data_valid;
  endtask

  task automatic test_reset;
    tick();
    tests_run++;
    if ({CENA, CENB, WENA, WENB} !== {2'b11, 8'hFF, 8'hFF}) begin
      tests_failed++;
      $display("FAIL reset_enables: got CENA=%b CENB=%b WENA=%h WENB=%h", CENA, CENB, WENA, WENB);
    end
    tests_run++;
    if ({AA, AB, DA, DB} !== '0) begin
      tests_failed++;
      $display("FAIL reset_bus: AA=%h AB=%h DA=%h DB=%h, required all 0", AA, AB, DA, DB);
    end
    tests_run++;
    if ({rd_data_valid, rd_data, init_busy, init_done} !== '0) begin
      tests_failed++;
      $display("FAIL reset_status: rd_data_valid=%b rd_data=%h busy=%b done=%b, required 0",
               rd_data_valid, rd_data, init_busy, init_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tests_run++;
    if ({ld_ready, wb_ready, rd_ready} !== 3'b001) begin
      tests_failed++;
      $display("FAIL idle_ready_novalid: ld/wb/rd ready=%b, required 001", {ld_ready, wb_ready, rd_ready});
    end
    ld_valid = 1'b1;
    #1;
    tests_run++;
    if ({ld_ready, wb_ready} !== 2'b10) begin
      tests_failed++;
      $display("FAIL idle_ready_ld: ld/wb ready=%b, required 10", {ld_ready, wb_ready});
    end
    ld_valid = 1'b0;
    wb_valid = 1'b1;
    #1;
    tests_run++;
    if ({ld_ready, wb_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL idle_ready_wb: ld/wb ready=%b, required 01", {ld_ready, wb_ready});
    end
    wb_valid = 1'b0;
    $display("[TB] reset/idle checks done");
  endtask

  task automatic test_ld_write_read;
    logic [DW-1:0] exp_v, got;
    logic          v;
    ld_valid = 1'b1;
    ld_addr  = 11'h005;
    ld_mask  = 8'h0F;
    ld_data  = {N{16'h1111}};
    tick();
    ld_valid = 1'b0;
    tests_run++;
    if ({CENA, WENA, AA} !== {1'b0, 8'hF0, {N{11'h005}}}) begin
      tests_failed++;
      $display("FAIL ld_porta: CENA=%b WENA=%h AA=%h, required 0/F0/replicated 005", CENA, WENA, AA);
    end
    tick();
    rd_valid = 1'b1;
    rd_addr  = 11'h005;
    tick();
    rd_valid = 1'b0;
    tests_run++;
    if ({CENB, AB, rd_data_valid} !== {1'b0, {N{11'h005}}, 1'b0}) begin
      tests_failed++;
      $display("FAIL rd_accept: CENB=%b AB=%h rd_data_valid=%b", CENB, AB, rd_data_valid);
    end
    tick();
    for (int l = 0; l < N; l++) exp_v[l*DATA_W +: DATA_W] = (l < 4) ? 16'h1111 : 16'hC000 + 16'(l);
    got = rd_data;
    v = rd_data_valid;
    tests_run++;
    if ({v, got} !== {1'b1, exp_v}) begin
      tests_failed++;
      $display("FAIL ld_readback: valid=%b data=%h, required 1/%h", v, got, exp_v);
    end
    tick();
    tests_run++;
    if ({rd_data_valid, rd_data, CENB} !== {1'b0, exp_v, 1'b1}) begin
      tests_failed++;
      $display("FAIL rd_valid_pulse: valid=%b data=%h CENB=%b, required 0/held/1", rd_data_valid, rd_data, CENB);
    end
    $display("[TB] ld write 0x005 mask 0F, read back data=%h", got);
  endtask

  task automatic test_arbitration;
    logic [1:0] exp_g;
    apply_reset();
    ld_valid = 1'b1; ld_addr = 11'h020; ld_mask = 8'hFF; ld_data = {N{16'h2222}};
    wb_valid = 1'b1; wb_addr = 11'h021; wb_mask = 8'hFF; wb_data = {N{16'h3333}};
    for (int k = 0; k < 6; k++) begin
      #1;
      exp_g = (k % 2 == 0) ? 2'b10 : 2'b01;
      tests_run++;
      if ({ld_ready, wb_ready} !== exp_g) begin
        tests_failed++;
        $display("FAIL rr_grant_%0d: ld/wb ready=%b, required %b", k, {ld_ready, wb_ready}, exp_g);
      end
      tick();
      tests_run++;
      if ({CENA, AA[ADDR_W-1:0]} !== {1'b0, (k % 2 == 0) ? 11'h020 : 11'h021}) begin
        tests_failed++;
        $display("FAIL rr_write_%0d: CENA=%b AA0=%h", k, CENA, AA[ADDR_W-1:0]);
      end
      $display("[TB] arb cycle %0d grant ld=%b wb=%b", k, exp_g[1], exp_g[0]);
    end
    ld_valid = 1'b0;
    wb_valid = 1'b0;
    tick();
  endtask

  task automatic test_init_clear;
    int            sweep_err;
    logic [DW-1:0] got;
    logic          v;
    sweep_err = 0;
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    ld_valid = 1'b1;
    #1;
    tests_run++;
    if ({init_busy, rd_ready, ld_ready} !== 3'b000) begin
      tests_failed++;
      $display("FAIL clear_entry: busy/rd_ready/ld_ready=%b, required 000", {init_busy, rd_ready, ld_ready});
    end
    ld_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      init_start = (i == 500);
      tick();
      if (CENA !== 1'b0 || WENA !== 8'h00 || AA[ADDR_W-1:0] !== ADDR_W'(i) ||
          init_busy !== 1'b1 || init_done !== 1'b0 || DA !== '0)
        sweep_err++;
    end
    init_start = 1'b0;
    tests_run++;
    if (sweep_err !== 0) begin
      tests_failed++;
      $display("FAIL clear_sweep: %0d bad cycles, required 0", sweep_err);
    end
    tests_run++;
    if (AA !== {N{11'h7FF}}) begin
      tests_failed++;
      $display("FAIL clear_last_addr: AA=%h, required replicated 7FF", AA);
    end
    tick();
    tests_run++;
    if ({init_done, init_busy, CENA} !== 3'b101) begin
      tests_failed++;
      $display("FAIL clear_done_pulse: done/busy/CENA=%b, required 101", {init_done, init_busy, CENA});
    end
    tick();
    tests_run++;
    if ({init_done, rd_ready} !== 2'b01) begin
      tests_failed++;
      $display("FAIL clear_done_end: done/rd_ready=%b, required 01", {init_done, rd_ready});
    end
    do_read(11'h7FF, got, v);
    tests_run++;
    if ({v, got} !== {1'b1, {DW{1'b0}}}) begin
      tests_failed++;
      $display("FAIL clear_read_7ff: valid=%b data=%h, required 1/0", v, got);
    end
    $display("[TB] zero-fill sweep done, read 0x7FF data=%h", got);
  endtask

  task automatic test_same_cycle_order;
    logic [DW-1:0] d0, d1;
    logic          v0, v1;
    ld_valid = 1'b1; ld_addr = 11'h010; ld_mask = 8'hFF; ld_data = {N{16'hABCD}};
    rd_valid = 1'b1; rd_addr = 11'h010;
    tick();
    ld_valid = 1'b0;
    tick();
    rd_valid = 1'b0;
    d0 = rd_data; v0 = rd_data_valid;
    tick();
    d1 = rd_data; v1 = rd_data_valid;
    tests_run++;
    if ({v0, d0} !== {1'b1, {DW{1'b0}}}) begin
      tests_failed++;
      $display("FAIL order_same_edge: valid=%b data=%h, required 1/old 0", v0, d0);
    end
    tests_run++;
    if ({v1, d1} !== {1'b1, {N{16'hABCD}}}) begin
      tests_failed++;
      $display("FAIL order_next_edge: valid=%b data=%h, required 1/ABCD", v1, d1);
    end
    $display("[TB] same-edge read=%h, next read=%h", d0[DATA_W-1:0], d1[DATA_W-1:0]);
    tick();
  endtask

  task automatic test_reset_mid_clear;
    int seen_done, seen_valid;
    seen_done = 0;
    seen_valid = 0;
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    repeat (100) tick();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({CENA, WENA, AA, init_busy} !== {1'b1, 8'hFF, {AW{1'b0}}, 1'b0}) begin
      tests_failed++;
      $display("FAIL abort_async: CENA=%b WENA=%h AA=%h busy=%b", CENA, WENA, AA, init_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (init_done !== 1'b0 || init_busy !== 1'b0 || CENA !== 1'b1) seen_done++;
    end
    tests_run++;
    if (seen_done !== 0) begin
      tests_failed++;
      $display("FAIL abort_no_done: %0d bad cycles after release, required 0", seen_done);
    end
    tests_run++;
    if (rd_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_idle: rd_ready=%b, required 1", rd_ready);
    end
    rd_valid = 1'b1;
    rd_addr  = 11'h000;
    tick();
    rd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    if (rd_data_valid !== 1'b0) seen_valid++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      tick();
      if (rd_data_valid !== 1'b0) seen_valid++;
    end
    tests_run++;
    if (seen_valid !== 0) begin
      tests_failed++;
      $display("FAIL abort_rd_drop: rd_data_valid seen %0d times, required 0", seen_valid);
    end
    $display("[TB] reset during clear at cnt=100 handled");
  endtask

  initial begin
    for (int l = 0; l < N; l++)
      for (int a = 0; a < DEPTH; a++)
        mem[l][a] = 16'hC000 + 16'(l);
    test_reset();
    test_ld_write_read();
    test_arbitration();
    test_init_clear();
    test_same_cycle_order();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_fsram_access_ctrl
